// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared types and default sizes for the write-back queue slice.
// Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // Register 0 is hard-wired in the bank, so writes to it are dropped.
  localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_fwd_lookup.sv
`default_nettype none
// ============================================================================
// Module   : wb_fwd_lookup
// Purpose  : Searches the queued write-backs for a register address and
//            returns the data of the youngest matching entry.
// Revision : 1.0  initial release
// ============================================================================
module wb_fwd_lookup
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [DEPTH-1:0]             ent_valid,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [ADDR_W-1:0]            query,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [c_PTR_W-1:0] w_idx;
  logic               w_query_zero;

  assign w_query_zero = (query == ADDR_W'(REG_ZERO));

  // Walk entries oldest to youngest; later matches overwrite earlier ones.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    w_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = head + c_PTR_W'(i);
      if (ent_valid[w_idx] && !w_query_zero && (ent_addr[w_idx] == query)) begin
        hit  = 1'b1;
        data = ent_data[w_idx];
      end
    end
  end

endmodule : wb_fwd_lookup
`default_nettype wire

// File: rtl/wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_write_queue
// Purpose  : In-order write-back FIFO feeding the register bank write port,
//            with two forwarding lookups for the decode-stage reads.
// Revision : 1.0  initial release
// ============================================================================
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    hold,
  output logic [ADDR_W-1:0]       A3,
  output logic [DATA_W-1:0]       wd3,
  output logic                    we3,
  input  logic [ADDR_W-1:0]       q1_addr,
  input  logic [ADDR_W-1:0]       q2_addr,
  output logic                    q1_hit,
  output logic                    q2_hit,
  output logic [DATA_W-1:0]       q1_data,
  output logic [DATA_W-1:0]       q2_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [DEPTH-1:0]             r_valid;
  logic [c_PTR_W-1:0]           r_rd_ptr;
  logic [c_PTR_W-1:0]           r_wr_ptr;
  logic [c_CNT_W-1:0]           r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Register-0 requests complete the handshake but are never stored.
  assign w_push = in_valid && !w_full && (in_addr != ADDR_W'(REG_ZERO));
  // Reset blocks the bank write so nothing lands on the reset edge.
  assign w_pop  = !w_empty && !hold && !rst;

  assign in_ready = !w_full;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign we3      = w_pop;
  assign A3       = w_empty ? '0 : r_addr[r_rd_ptr];
  assign wd3      = w_empty ? '0 : r_data[r_rd_ptr];

  // Control state: pointers, occupancy and per-slot valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while the slot is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= in_addr;
      r_data[r_wr_ptr] <= in_data;
    end
  end

  wb_fwd_lookup #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_lookup_q1 (
    .ent_addr (r_addr),
    .ent_data (r_data),
    .ent_valid(r_valid),
    .head     (r_rd_ptr),
    .query    (q1_addr),
    .hit      (q1_hit),
    .data     (q1_data)
  );

  wb_fwd_lookup #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_lookup_q2 (
    .ent_addr (r_addr),
    .ent_data (r_data),
    .ent_valid(r_valid),
    .head     (r_rd_ptr),
    .query    (q2_addr),
    .hit      (q2_hit),
    .data     (q2_data)
  );

endmodule : wb_write_queue
`default_nettype wire

// File: tb/tb_wb_write_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_write_queue
// Purpose  : Self-checking bench for wb_write_queue: directed vector table
//            followed by random traffic against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_write_queue;
  import wb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              hold;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] wd3;
  logic              we3;
  logic [ADDR_W-1:0] q1_addr, q2_addr;
  logic              q1_hit, q2_hit;
  logic [DATA_W-1:0] q1_data, q2_data;
  logic [CNT_W-1:0]  count;
  logic              full, empty;

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold),
    .A3(A3), .wd3(wd3), .we3(we3),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_hit(q1_hit), .q2_hit(q2_hit),
    .q1_data(q1_data), .q2_data(q2_data),
    .count(count), .full(full), .empty(empty)
  );

  // Stand-in for banco_reg: captures whatever the queue writes.
  logic [DATA_W-1:0] dbank [32] = '{default: '0};
  always @(posedge clk) if (we3) dbank[A3] <= wd3;

  typedef struct {
    logic        rst, vld;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        hold;
    logic [4:0]  q1, q2;
    logic [2:0]  e_cnt;
    logic        e_we3;
    logic [4:0]  e_a3;
    logic [31:0] e_wd3;
    logic        e_rdy, e_h1;
    logic [31:0] e_d1;
    logic        e_h2;
    logic [31:0] e_d2;
  } vec_t;

  vec_t vecs[$];

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a plain queue of entries plus the expected bank image.
  wb_entry_t   mq[$];
  logic [31:0] mbank [32] = '{default: '0};
  logic [CNT_W-1:0] prev_cnt;
  logic             prev_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic add(input logic r, input logic v, input logic [4:0] a, input logic [31:0] d,
                     input logic h, input logic [4:0] x1, input logic [4:0] x2,
                     input logic [2:0] c, input logic w, input logic [4:0] ea,
                     input logic [31:0] ed, input logic rd, input logic h1,
                     input logic [31:0] d1, input logic h2, input logic [31:0] d2);
    vec_t t;
    t = '{r, v, a, d, h, x1, x2, c, w, ea, ed, rd, h1, d1, h2, d2};
    vecs.push_back(t);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst = v.rst; in_valid = v.vld; in_addr = v.addr; in_data = v.data;
    hold = v.hold; q1_addr = v.q1; q2_addr = v.q2;
    #1;
  endtask

  function automatic void mlook(input logic [4:0] q, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (q != 5'd0)
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].addr == q) begin
          h = 1'b1;
          d = mq[i].data;
          break;
        end
  endfunction

  task automatic check_model();
    logic h1, h2;
    logic [31:0] d1, d2;
    int sz;
    sz = mq.size();
    mlook(q1_addr, h1, d1);
    mlook(q2_addr, h2, d2);
    chk("count", count, sz);
    chk("full", full, sz == DEPTH);
    chk("empty", empty, sz == 0);
    chk("in_ready", in_ready, sz != DEPTH);
    chk("we3", we3, sz > 0 && !hold && !rst);
    chk("A3", A3, sz > 0 ? mq[0].addr : 5'd0);
    chk("wd3", wd3, sz > 0 ? mq[0].data : 32'd0);
    chk("q1_hit", q1_hit, h1);
    chk("q1_data", q1_data, d1);
    chk("q2_hit", q2_hit, h2);
    chk("q2_data", q2_data, d2);
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("[%0d]", idx);
    chk({"vec count", s}, count, v.e_cnt);
    chk({"vec full", s}, full, v.e_cnt == 3'd4);
    chk({"vec empty", s}, empty, v.e_cnt == 3'd0);
    chk({"vec we3", s}, we3, v.e_we3);
    chk({"vec A3", s}, A3, v.e_a3);
    chk({"vec wd3", s}, wd3, v.e_wd3);
    chk({"vec in_ready", s}, in_ready, v.e_rdy);
    chk({"vec q1_hit", s}, q1_hit, v.e_h1);
    chk({"vec q1_data", s}, q1_data, v.e_d1);
    chk({"vec q2_hit", s}, q2_hit, v.e_h2);
    chk({"vec q2_data", s}, q2_data, v.e_d2);
  endtask

  // Occupancy must stay within 0..DEPTH and move by at most one per edge.
  task automatic check_count_range();
    int delta;
    delta = int'(count) - int'(prev_cnt);
    n_total++;
    a_count_step: assert (count <= CNT_W'(DEPTH) && (prev_rst || (delta >= -1 && delta <= 1)))
      n_pass++;
    else
      $display("FAIL count_range: got %0d previous %0d", count, prev_cnt);
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_step();
    bit do_pop, do_push;
    do_pop  = !rst && mq.size() > 0 && !hold;
    do_push = in_valid && mq.size() < DEPTH && in_addr != 5'd0;
    if (rst) begin
      mq.delete();
    end else begin
      if (do_pop) begin
        mbank[mq[0].addr] = mq[0].data;
        void'(mq.pop_front());
      end
      if (do_push) mq.push_back('{in_addr, in_data});
    end
    prev_cnt = count;
    prev_rst = rst;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    hold = 1'b0; q1_addr = '0; q2_addr = '0;
    v = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    drive(v);
    model_step();

    //   rst vld addr data          hold q1  q2  | cnt we3 A3  wd3           rdy h1 d1            h2 d2
    add(0, 0, 0,  32'h0,        0, 0,  0,  0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 1, 5,  32'hDEADBEEF, 0, 5,  0,  0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 5,  0,  1, 1, 5,  32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 5,  0,  0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 1, 1,  32'h11,       1, 1,  4,  0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 1, 2,  32'h22,       1, 1,  4,  1, 0, 1,  32'h11,       1, 1, 32'h11,       0, 32'h0);
    add(0, 1, 3,  32'h33,       1, 1,  4,  2, 0, 1,  32'h11,       1, 1, 32'h11,       0, 32'h0);
    add(0, 1, 1,  32'h44,       1, 1,  4,  3, 0, 1,  32'h11,       1, 1, 32'h11,       0, 32'h0);
    add(0, 1, 4,  32'h55,       1, 1,  4,  4, 0, 1,  32'h11,       0, 1, 32'h44,       0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 1,  4,  4, 1, 1,  32'h11,       0, 1, 32'h44,       0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 1,  4,  3, 1, 2,  32'h22,       1, 1, 32'h44,       0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 1,  4,  2, 1, 3,  32'h33,       1, 1, 32'h44,       0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 1,  4,  1, 1, 1,  32'h44,       1, 1, 32'h44,       0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 1,  4,  0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 1, 0,  32'hFFFFFFFF, 0, 0,  0,  0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 0,  0,  0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 1, 7,  32'h70,       1, 7,  8,  0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 1, 8,  32'h80,       1, 7,  8,  1, 0, 7,  32'h70,       1, 1, 32'h70,       0, 32'h0);
    add(0, 1, 9,  32'h90,       0, 7,  8,  2, 1, 7,  32'h70,       1, 1, 32'h70,       1, 32'h80);
    add(0, 1, 10, 32'hA0,       0, 7,  8,  2, 1, 8,  32'h80,       1, 0, 32'h0,        1, 32'h80);
    add(0, 1, 11, 32'hB0,       0, 7,  8,  2, 1, 9,  32'h90,       1, 0, 32'h0,        0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 7,  8,  2, 1, 10, 32'hA0,       1, 0, 32'h0,        0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 7,  8,  1, 1, 11, 32'hB0,       1, 0, 32'h0,        0, 32'h0);
    add(0, 0, 0,  32'h0,        0, 7,  8,  0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 1, 12, 32'hC0,       1, 12, 13, 0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);
    add(0, 1, 13, 32'hD0,       1, 12, 13, 1, 0, 12, 32'hC0,       1, 1, 32'hC0,       0, 32'h0);
    add(0, 1, 14, 32'hE0,       1, 12, 13, 2, 0, 12, 32'hC0,       1, 1, 32'hC0,       1, 32'hD0);
    add(0, 0, 0,  32'h0,        0, 12, 13, 3, 1, 12, 32'hC0,       1, 1, 32'hC0,       1, 32'hD0);
    add(1, 0, 0,  32'h0,        0, 12, 13, 2, 0, 13, 32'hD0,       1, 0, 32'h0,        1, 32'hD0);
    add(0, 0, 0,  32'h0,        0, 12, 13, 0, 0, 0,  32'h0,        1, 0, 32'h0,        0, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      check_vec(vecs[i], i);
      check_count_range();
      model_step();
    end

    // Bank contents left by the directed sequence.
    @(negedge clk);
    chk("bank r5", dbank[5], 32'hDEADBEEF);
    chk("bank r1 last write", dbank[1], 32'h44);
    chk("bank r0 untouched", dbank[0], 32'h0);
    chk("bank r11", dbank[11], 32'hB0);
    chk("bank r12", dbank[12], 32'hC0);
    chk("bank r13 aborted", dbank[13], 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      v.rst  = ($urandom_range(0, 79) == 0);
      v.vld  = ($urandom_range(0, 9) < 6);
      v.addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      v.data = $urandom;
      v.hold = ($urandom_range(0, 9) < 4);
      v.q1   = 5'($urandom_range(0, 7));
      v.q2   = 5'($urandom_range(0, 7));
      drive(v);
      check_model();
      check_count_range();
      model_step();
    end

    @(negedge clk);
    for (int r = 0; r < 32; r++) chk($sformatf("bank r%0d", r), dbank[r], mbank[r]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_wb_write_queue
`default_nettype wire
